// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the sequential restoring divider.
//   state_t  : divider FSM states (IDLE, RUN, FIX)
//   MAX_W    : widest operand the helper functions handle
//   cond_neg : conditional two's-complement negate. Callers zero-extend their
//              operand to MAX_W bits and keep the low WIDTH bits of the
//              result, which is the negate at WIDTH bits.
// ---------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int MAX_W = 128;

   function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] value,
                                                 input logic             flag);
      return flag ? -value : value;
   endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   accu_i : partial remainder in (always below m_i when m_i != 0)
//   q_i    : dividend/quotient shift register in
//   m_i    : divisor magnitude
//   accu_o : partial remainder out
//   q_o    : shift register out, new quotient bit in bit 0
// ---------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] accu_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] accu_o,
   output logic [WIDTH-1:0] q_o
);

   // The shifted remainder needs one extra bit before the compare.
   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;
   logic           ge;

   always_comb begin
      sh     = {accu_i, q_i[WIDTH-1]};
      diff   = sh - {1'b0, m_i};
      ge     = (sh >= {1'b0, m_i});
      accu_o = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
      q_o    = {q_i[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/divisor_secuencial_param.sv
// ---------------------------------------------------------------------------
// divisor_secuencial_param
// Sequential restoring divider, signed or unsigned per operation, retiring
// STEPS quotient bits per clock. Quotient truncates toward zero, remainder
// takes the sign of Num. Result latency is WIDTH/STEPS + 2 cycles.
//
// Build option DIVISOR_DIVZERO_EN: when defined, Den = 0 is detected at
// accept, RUN is skipped and DivZero is raised; otherwise DivZero is tied 0
// and a zero divisor simply runs the normal iteration.
//
// Ports:
//   CLK, RSTa     : clock (rising edge), async active-low reset
//   Start, Ready  : request / accept handshake
//   Sgn, Num, Den : mode and operands, sampled at accept
//   Coc, Res      : quotient and remainder, held until the next result
//   Done          : one-cycle pulse when Coc/Res/DivZero are rewritten
//   DivZero       : held result came from a zero divisor
// ---------------------------------------------------------------------------
module divisor_secuencial_param
   import div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input  logic             CLK,
   input  logic             RSTa,
   input  logic             Start,
   input  logic             Sgn,
   input  logic [WIDTH-1:0] Num,
   input  logic [WIDTH-1:0] Den,
   output logic             Ready,
   output logic [WIDTH-1:0] Coc,
   output logic [WIDTH-1:0] Res,
   output logic             Done,
   output logic             DivZero
);

   localparam int L     = WIDTH / STEPS;
   localparam int CNT_W = $clog2(L + 1);

   if (WIDTH % STEPS != 0) begin : g_bad_steps
      $error("divisor_secuencial_param: STEPS must divide WIDTH");
   end
   if (WIDTH < 4 || WIDTH > MAX_W) begin : g_bad_width
      $error("divisor_secuencial_param: WIDTH out of range");
   end

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               sn_q;
   logic               sd_q;
   logic [WIDTH-1:0]   accu_q;
   logic [WIDTH-1:0]   q_q;
   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   coc_q;
   logic [WIDTH-1:0]   res_q;
   logic               done_q;
   logic               accept;
`ifdef DIVISOR_DIVZERO_EN
   logic               dz_q;
   logic               divzero_q;
`endif

   // Restoring step chain; index STEPS is the next-state of the datapath.
   logic [WIDTH-1:0]   accu_d [0:STEPS];
   logic [WIDTH-1:0]   q_d    [0:STEPS];

   assign accu_d[0] = accu_q;
   assign q_d[0]    = q_q;

   for (genvar g = 0; g < STEPS; g++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
         .accu_i (accu_d[g]),
         .q_i    (q_d[g]),
         .m_i    (m_q),
         .accu_o (accu_d[g+1]),
         .q_o    (q_d[g+1])
      );
   end

   assign Ready  = (state_q == IDLE);
   assign accept = Ready & Start;

   // Control FSM and result registers.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sn_q      <= 1'b0;
         sd_q      <= 1'b0;
         coc_q     <= '0;
         res_q     <= '0;
         done_q    <= 1'b0;
`ifdef DIVISOR_DIVZERO_EN
         dz_q      <= 1'b0;
         divzero_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Start) begin
                  sn_q  <= Sgn & Num[WIDTH-1];
                  sd_q  <= Sgn & Den[WIDTH-1];
                  cnt_q <= CNT_W'(L - 1);
`ifdef DIVISOR_DIVZERO_EN
                  dz_q    <= (Den == '0);
                  state_q <= (Den == '0) ? FIX : RUN;
`else
                  state_q <= RUN;
`endif
               end
            end
            RUN: begin
               if (cnt_q == '0) state_q <= FIX;
               else             cnt_q   <= cnt_q - CNT_W'(1);
            end
            FIX: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               coc_q   <= WIDTH'(cond_neg(MAX_W'(q_q), sn_q ^ sd_q));
               res_q   <= WIDTH'(cond_neg(MAX_W'(accu_q), sn_q));
`ifdef DIVISOR_DIVZERO_EN
               divzero_q <= dz_q;
               // Q still holds |Num| because RUN was skipped.
               if (dz_q) begin
                  coc_q <= '1;
                  res_q <= WIDTH'(cond_neg(MAX_W'(q_q), sn_q));
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; they are always loaded at accept.
   always_ff @(posedge CLK) begin
      if (accept) begin
         q_q    <= WIDTH'(cond_neg(MAX_W'(Num), Sgn & Num[WIDTH-1]));
         m_q    <= WIDTH'(cond_neg(MAX_W'(Den), Sgn & Den[WIDTH-1]));
         accu_q <= '0;
      end else if (state_q == RUN) begin
         accu_q <= accu_d[STEPS];
         q_q    <= q_d[STEPS];
      end
   end

   assign Coc  = coc_q;
   assign Res  = res_q;
   assign Done = done_q;
`ifdef DIVISOR_DIVZERO_EN
   assign DivZero = divzero_q;
`else
   assign DivZero = 1'b0;
`endif

endmodule

// File: doc/divisor_secuencial_param.md
# divisor_secuencial_param

Parametrised sequential restoring divider. It divides an N-bit numerator by an N-bit denominator and runs in signed or unsigned mode, selected per operation. It retires a configurable number of quotient bits per clock and accepts operands through a Start/Ready handshake. It is the general-purpose divide engine used wherever a multi-cycle quotient/remainder is acceptable.

## Interface
- WIDTH, 32: operand and result width; WIDTH ≥ 4.
- STEPS, 1: quotient bits retired per cycle. Must divide WIDTH; an elaboration error is required otherwise.
- CLK  in  1  clock, rising edge.
- RSTa  in  1  reset, asynchronous, active-low.
- Start  in  1  operation request; accepted only when Ready=1.
- Sgn  in  1  1 = two's-complement operands, 0 = unsigned. Sampled at accept.
- Num  in  WIDTH  dividend, sampled at accept.
- Den  in  WIDTH  divisor, sampled at accept.
- Ready  out  WIDTH-independent 1  engine can accept Start this cycle.
- Coc  out  WIDTH  quotient, held until the next result write.
- Res  out  WIDTH  remainder, held until the next result write.
- Done  out  1  one-cycle pulse: Coc/Res/DivZero valid and newly written.
- DivZero  out  1  Den was 0 for the result currently held.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, Start=1 → RUN. At this edge:
  - latch Sgn;
  - latch signs SN = Sgn & Num[MSB] and SD = Sgn & Den[MSB];
  - Q = |Num| and M = |Den| (negate when the sign flag is set), ACCU = 0;
  - CNT = WIDTH/STEPS − 1.
- RUN: each cycle applies STEPS restoring steps in sequence. One step is:
  - shift {ACCU,Q} left by 1;
  - if ACCU ≥ M, then ACCU −= M and Q[0] = 1.
- RUN exit: CNT decrements each cycle. When CNT = 0 the state goes to FIX, otherwise it stays in RUN.
- FIX → IDLE. At this edge:
  - Coc = (SN^SD) ? −Q : Q;
  - Res = SN ? −ACCU : ACCU;
  - DivZero is written;
  - Done = 1 for the following cycle.
- Rounding and signs:
  - the quotient truncates toward zero;
  - the remainder takes the sign of Num;
  - Num = Coc·Den + Res holds modulo 2^WIDTH.
- Signed overflow: MIN / −1 gives Coc = MIN (wraps) and Res = 0. No flag is raised.
- Magnitudes are unsigned WIDTH bits. |MIN| = 2^(WIDTH−1) is exact.
- Ready is 1 in IDLE and 0 in RUN/FIX.
- Start is ignored while Ready=0. Sgn, Num and Den need not be stable after accept.
- Back-to-back: Start in the Done cycle is accepted, because the state is IDLE then.

## Timing
- Accept edge = edge 0. Let L = WIDTH/STEPS.
- RUN occupies edges 1..L. The FIX result write happens at edge L+1.
- Done is high during the cycle after edge L+1.
- Throughput is one operation per L+2 cycles.
- Reset, asynchronous, including mid-operation:
  - state = IDLE;
  - Coc = Res = 0 and Done = DivZero = 0;
  - Ready = 1 immediately;
  - an interrupted operation produces no Done.
- Done is never asserted outside the single cycle after FIX.

## Configuration
- Macro DIVISOR_DIVZERO_EN.
- Defined:
  - Den = 0 at accept skips RUN and goes IDLE → FIX directly, so Done comes 2 cycles after accept;
  - the result is Coc = all ones, Res = Num, DivZero = 1;
  - for every other divisor, DivZero = 0.
- Undefined:
  - no detection; DivZero is tied 0;
  - Den = 0 runs the full L+2 cycles;
  - the result is Res = Num and Coc = all ones, except signed mode with Num < 0, where Coc = 1.

## Structure
- Package div_pkg:
  - state enum typedef (IDLE, RUN, FIX);
  - function cond_neg(value, flag) returning the conditional two's-complement negate.
- Sub-module div_step: combinational single restoring step.
  - Inputs: ACCU, Q, M.
  - Outputs: ACCU', Q'.
  - Instantiated STEPS times in a generate chain.

## Test plan
- Unsigned, WIDTH=32, STEPS=1: 100/7. Require Done 34 cycles after accept, Coc=14, Res=2, DivZero=0.
- Signed −7/2 → Coc=−3, Res=−1. Signed 7/−2 → Coc=−3, Res=1. Signed MIN/−1 → Coc=MIN, Res=0.
- Den=0, Num=5, defined and undefined:
  - macro defined: Done 2 cycles after accept, Coc=0xFFFFFFFF, Res=5, DivZero=1;
  - macro undefined: Done at 34 cycles, same Coc/Res, DivZero=0.
- STEPS=4, 0xFFFFFFFF/0x10 unsigned → Done after 10 cycles, Coc=0x0FFFFFFF, Res=0xF.
- Back-to-back: second Start in the Done cycle is accepted. Start pulses during RUN are ignored and produce no extra Done.
- RSTa low mid-RUN → outputs 0 and Ready=1 immediately, no Done. A fresh 9/3 afterwards yields Coc=3, Res=0.
